// File: rtl/caravel_wb_pkg.sv
// Shared definitions for the caravel_wb bus: widths, responder state encoding,
// the captured memory command payload and a saturating counter helper.
package caravel_wb_pkg;

  localparam int unsigned WB_DATA_WIDTH            = 32;
  localparam int unsigned WB_SEL_WIDTH             = 4;
  localparam int unsigned CARAVEL_WB_ADDRESS_WIDTH = 28;
  localparam int unsigned ERROR_COUNT_WIDTH        = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_RESPOND = 2'd2,
    ST_ERROR   = 2'd3
  } wb_state_e;

  // Write-side payload captured on accept and presented to the memory port.
  typedef struct packed {
    logic                     we;
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  function automatic logic [ERROR_COUNT_WIDTH-1:0] sat_inc(input logic [ERROR_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERROR_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-state counter for the responder's timeout build.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     hold the count at zero
//   enable    count one wait cycle
//   expired   registered flag, high while the count equals LIMIT (count freezes there)
module wb_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LIMIT_W = CW'(LIMIT);

  logic [CW-1:0] count_q;

  // expired is registered alongside the count so it reflects (count == LIMIT) without a compare on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      count_q <= count_q + CW'(1);
      expired <= ((count_q + CW'(1)) == LIMIT_W);
    end
  end

endmodule

// File: rtl/caravel_wb_responder.sv
// Wishbone (pipelined) slave that forwards single transactions to a
// variable-latency word-addressed memory port and returns ack/error/read data.
// One window of 4*2^MEM_ADDRESS_WIDTH bytes at BASE_ADDRESS is decoded; any
// other or misaligned address gets an error response.
// Optional build macro CARAVEL_WB_RESPONDER_TIMEOUT_EN: abort a memory request
// with an error after TIMEOUT_CYCLES wait states.
// Ports:
//   wb_clk_i, wb_rst_i                    clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i/sel_i/data_i/adr_i  initiator request
//   wb_ack_o, wb_error_o, wb_stall_o, wb_data_o  response (data only during read ack)
//   mem_req_o/we_o/sel_o/adr_o/wdata_o    memory request, held until mem_ready_i
//   mem_ready_i, mem_rdata_i              memory completion and read data
//   busy_o                                transaction in flight
//   error_count_o                         saturating count of error responses
module caravel_wb_responder
  import caravel_wb_pkg::*;
#(
  parameter logic [CARAVEL_WB_ADDRESS_WIDTH-1:0] BASE_ADDRESS = 28'h0000000,
  parameter int unsigned MEM_ADDRESS_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic                                wb_cyc_i,
  input  logic                                wb_stb_i,
  input  logic                                wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]             wb_sel_i,
  input  logic [WB_DATA_WIDTH-1:0]            wb_data_i,
  input  logic [CARAVEL_WB_ADDRESS_WIDTH-1:0] wb_adr_i,
  output logic                                wb_ack_o,
  output logic                                wb_stall_o,
  output logic                                wb_error_o,
  output logic [WB_DATA_WIDTH-1:0]            wb_data_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [WB_SEL_WIDTH-1:0]             mem_sel_o,
  output logic [MEM_ADDRESS_WIDTH-1:0]        mem_adr_o,
  output logic [WB_DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic                                mem_ready_i,
  input  logic [WB_DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                                busy_o,
  output logic [ERROR_COUNT_WIDTH-1:0]        error_count_o
);

  localparam int unsigned AW  = CARAVEL_WB_ADDRESS_WIDTH;
  localparam int unsigned MAW = MEM_ADDRESS_WIDTH;
  localparam logic [AW:0] WINDOW_BYTES = (AW + 1)'(1) << (MAW + 2);

  // Elaboration-time parameter sanity checks.
  if (BASE_ADDRESS[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_ADDRESS must be 4-byte aligned");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  wb_state_e state_q, state_d;
  mem_cmd_t  cmd_q, cmd_d;
  logic [MAW-1:0] adr_d;
  logic [ERROR_COUNT_WIDTH-1:0] err_cnt_d;
  logic [WB_DATA_WIDTH-1:0] rdata_d;
  logic aborted_q, aborted_d;
  logic ack_d, err_d;
  logic timeout_expired;

  // Address decode: offset from base, computed at bus width; addresses below base never wrap into the window.
  logic [AW-1:0] offset;
  logic in_window, aligned;
  assign offset    = wb_adr_i - BASE_ADDRESS;
  assign in_window = (wb_adr_i >= BASE_ADDRESS) && ({1'b0, offset} < WINDOW_BYTES);
  assign aligned   = (wb_adr_i[1:0] == 2'b00);

`ifdef CARAVEL_WB_RESPONDER_TIMEOUT_EN
  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (state_q != ST_REQUEST),
    .enable  ((state_q == ST_REQUEST) && !mem_ready_i),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  // Next-state and registered-output values. Responses are decided on the edge
  // that enters RESPOND/ERROR, so cyc is sampled there; once cyc has been seen
  // low during a transaction the response stays suppressed.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    adr_d     = mem_adr_o;
    aborted_d = aborted_q;
    err_cnt_d = error_count_o;
    rdata_d   = '0;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    if (state_q != ST_IDLE && !wb_cyc_i) aborted_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          aborted_d = 1'b0;
          if (aligned && in_window) begin
            state_d = ST_REQUEST;
            cmd_d   = '{we: wb_we_i, sel: wb_sel_i, wdata: wb_data_i};
            adr_d   = offset[MAW+1:2];
          end else begin
            state_d   = ST_ERROR;
            err_d     = 1'b1;
            err_cnt_d = sat_inc(error_count_o);
          end
        end
      end
      ST_REQUEST: begin
        if (mem_ready_i) begin
          state_d = ST_RESPOND;
          if (wb_cyc_i && !aborted_q) begin
            ack_d = 1'b1;
            if (!cmd_q.we) rdata_d = mem_rdata_i;
          end
        end else if (timeout_expired) begin
          state_d   = ST_ERROR;
          err_d     = wb_cyc_i && !aborted_q;
          err_cnt_d = sat_inc(error_count_o);
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      ST_ERROR:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      aborted_q     <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_error_o    <= 1'b0;
      wb_stall_o    <= 1'b0;
      wb_data_o     <= '0;
      mem_req_o     <= 1'b0;
      mem_adr_o     <= '0;
      busy_o        <= 1'b0;
      error_count_o <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      aborted_q     <= aborted_d;
      wb_ack_o      <= ack_d;
      wb_error_o    <= err_d;
      wb_stall_o    <= (state_d != ST_IDLE);
      wb_data_o     <= rdata_d;
      mem_req_o     <= (state_d == ST_REQUEST);
      mem_adr_o     <= adr_d;
      busy_o        <= (state_d != ST_IDLE);
      error_count_o <= err_cnt_d;
    end
  end

  assign mem_we_o    = cmd_q.we;
  assign mem_sel_o   = cmd_q.sel;
  assign mem_wdata_o = cmd_q.wdata;

endmodule
